// File: rtl/psg_register_bus.sv
// psg_register_bus
//   Host write port and register file of an SN76489-style PSG. Decodes the
//   latch/data byte protocol into three tone periods, four attenuations and
//   the noise control. It also models the chip's READY lockout: after an
//   accepted write, further writes are refused until READY_CYCLES chip-clock
//   enables have elapsed.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   enable             chip-clock enable; it only paces the busy countdown
//   we, data           level write strobe (its rising edge is a write) and byte
//   ready              high when a write edge will be accepted
//   tone0..2_freq      tone periods (low 10 bits writable)
//   atten0..3          attenuations (atten3 = noise channel), 4'hF = silent
//   noise_control      {FB, NF1, NF0}
//   restart_noise      one-cycle pulse after any noise-register write
module psg_register_bus #(
  parameter int COUNTER_BITS = 10,
  parameter int READY_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    we,
  input  logic [7:0]              data,
  output logic                    ready,
  output logic [COUNTER_BITS-1:0] tone0_freq,
  output logic [COUNTER_BITS-1:0] tone1_freq,
  output logic [COUNTER_BITS-1:0] tone2_freq,
  output logic [3:0]              atten0,
  output logic [3:0]              atten1,
  output logic [3:0]              atten2,
  output logic [3:0]              atten3,
  output logic [2:0]              noise_control,
  output logic                    restart_noise
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            we_prev_q;
  logic [2:0]      lat_q, lat_d;
  logic [2:0][9:0] tone_q, tone_d;
  logic [3:0][3:0] atten_q, atten_d;
  logic [2:0]      noise_q, noise_d;
  logic            restart_q, restart_d;

  logic       wr_acc;
  logic [2:0] reg_sel;
  logic [1:0] r;
  logic       t;

  // An edge seen while busy is simply lost; nothing is queued.
  assign wr_acc  = we & ~we_prev_q & (state_q == ST_IDLE);
  // A latch byte addresses its own register; a data byte reuses the latch.
  assign reg_sel = data[7] ? data[6:4] : lat_q;
  assign r       = reg_sel[2:1];
  assign t       = reg_sel[0];

  always_comb begin
    lat_d     = lat_q;
    tone_d    = tone_q;
    atten_d   = atten_q;
    noise_d   = noise_q;
    restart_d = 1'b0;
    if (wr_acc) begin
      if (data[7]) lat_d = data[6:4];
      if (t) begin
        atten_d[r] = data[3:0];
      end else if (r == 2'd3) begin
        noise_d   = data[2:0];
        restart_d = 1'b1;
      end else if (data[7]) begin
        tone_d[r][3:0] = data[3:0];
      end else begin
        tone_d[r][9:4] = data[5:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc) begin
          state_d = ST_BUSY;
          cnt_d   = 8'(READY_CYCLES);
        end
      end
      ST_BUSY: begin
        if (enable) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_prev_q <= 1'b0;
      lat_q     <= 3'b000;
      tone_q    <= '0;
      atten_q   <= {4{4'hF}};
      noise_q   <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_prev_q <= we;
      lat_q     <= lat_d;
      tone_q    <= tone_d;
      atten_q   <= atten_d;
      noise_q   <= noise_d;
      restart_q <= restart_d;
    end
  end

  assign ready         = (state_q == ST_IDLE);
  assign atten0        = atten_q[0];
  assign atten1        = atten_q[1];
  assign atten2        = atten_q[2];
  assign atten3        = atten_q[3];
  assign noise_control = noise_q;
  assign restart_noise = restart_q;

  // Bits above the 10-bit chip register are never written and read as 0.
  generate
    if (COUNTER_BITS > 10) begin : g_wide
      assign tone0_freq = {{(COUNTER_BITS-10){1'b0}}, tone_q[0]};
      assign tone1_freq = {{(COUNTER_BITS-10){1'b0}}, tone_q[1]};
      assign tone2_freq = {{(COUNTER_BITS-10){1'b0}}, tone_q[2]};
    end else begin : g_narrow
      assign tone0_freq = tone_q[0][COUNTER_BITS-1:0];
      assign tone1_freq = tone_q[1][COUNTER_BITS-1:0];
      assign tone2_freq = tone_q[2][COUNTER_BITS-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_psg_register_bus.sv
module tb_psg_register_bus;
  localparam int CB = 10;
  localparam int RC = 32;

  logic          clk = 1'b0;
  logic          reset, enable, we;
  logic [7:0]    data;
  logic          ready, restart_noise;
  logic [CB-1:0] tone0_freq, tone1_freq, tone2_freq;
  logic [3:0]    atten0, atten1, atten2, atten3;
  logic [2:0]    noise_control;

  psg_register_bus #(.COUNTER_BITS(CB), .READY_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .we(we), .data(data),
    .ready(ready), .tone0_freq(tone0_freq), .tone1_freq(tone1_freq),
    .tone2_freq(tone2_freq), .atten0(atten0), .atten1(atten1),
    .atten2(atten2), .atten3(atten3), .noise_control(noise_control),
    .restart_noise(restart_noise)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_tone [3];
  int   m_att  [4];
  int   m_noise;
  int   m_lat;
  int   m_busy;      // enables still owed before writes are taken again
  bit   m_prev;
  bit   m_restart;
  bit   chk_on = 0;

  task automatic m_reset();
    foreach (m_tone[i]) m_tone[i] = 0;
    foreach (m_att[i])  m_att[i]  = 15;
    m_noise = 0; m_lat = 0; m_busy = 0; m_prev = 0; m_restart = 0;
  endtask

  task automatic m_write(input logic [7:0] b);
    int reg_id, ch;
    if (b[7]) begin
      m_lat = int'(b[6:4]);
    end
    reg_id = m_lat;
    ch = reg_id / 2;
    if (reg_id % 2 == 1)      m_att[ch] = int'(b[3:0]);
    else if (ch == 3) begin   m_noise = int'(b[2:0]); m_restart = 1; end
    else if (b[7])            m_tone[ch] = (m_tone[ch] / 16) * 16 + int'(b[3:0]);
    else                      m_tone[ch] = (m_tone[ch] % 16) + int'(b[5:0]) * 16;
  endtask

  initial m_reset();

  always @(posedge clk) begin
    m_restart = 0;
    if (reset) m_reset();
    else begin
      if (m_busy > 0) begin
        if (enable) m_busy--;
      end else if (we && !m_prev) begin
        m_write(data);
        m_busy = RC;
      end
      m_prev = we;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("ready",   32'(ready),         32'(m_busy == 0));
    chk("tone0",   32'(tone0_freq),    32'(m_tone[0]));
    chk("tone1",   32'(tone1_freq),    32'(m_tone[1]));
    chk("tone2",   32'(tone2_freq),    32'(m_tone[2]));
    chk("atten0",  32'(atten0),        32'(m_att[0]));
    chk("atten1",  32'(atten1),        32'(m_att[1]));
    chk("atten2",  32'(atten2),        32'(m_att[2]));
    chk("atten3",  32'(atten3),        32'(m_att[3]));
    chk("noise",   32'(noise_control), 32'(m_noise));
    chk("restart", 32'(restart_noise), 32'(m_restart));
  end

  // ---------------- stimulus ----------------
  bit en_div4 = 0;
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    enable = en_div4 ? (cyc % 4 == 0) : 1'b1;
  end

  // Issue one write edge, then count cycles with ready low (bounded).
  task automatic wr(input logic [7:0] b, output int low, output bit rs0, output bit rs1);
    data = b; we = 1'b1;
    @(negedge clk); we = 1'b0;
    rs0 = restart_noise;
    low = 0;
    while (!ready && low < 2000) begin
      low++;
      @(negedge clk);
      if (low == 1) rs1 = restart_noise;
    end
    if (low >= 2000) chk("ready_timeout", 32'(low), 32'(RC));
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  int low; bit rs0, rs1;

  initial begin
    reset = 1'b1; we = 1'b0; data = 8'h00; enable = 1'b1;
    ticks(2);
    chk_on = 1;
    reset = 1'b0;
    ticks(1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_att3",  32'(atten3), 32'hF);
    chk("rst_tone0", 32'(tone0_freq), 32'h0);

    // tone0 low nibble, then high six bits
    wr(8'h8E, low, rs0, rs1);
    chk("lowlen_8E", 32'(low), 32'(RC));
    chk("tone0_E",   32'(tone0_freq), 32'h00E);
    wr(8'h0F, low, rs0, rs1);
    chk("lowlen_0F", 32'(low), 32'(RC));
    chk("tone0_0FE", 32'(tone0_freq), 32'h0FE);

    // noise latch and data bytes, each with one restart pulse
    wr(8'hE5, low, rs0, rs1);
    chk("noise_101", 32'(noise_control), 32'b101);
    chk("rst_pulse1", {30'd0, rs0, rs1}, 32'b10);
    wr(8'h03, low, rs0, rs1);
    chk("noise_011", 32'(noise_control), 32'b011);
    chk("rst_pulse2", {30'd0, rs0, rs1}, 32'b10);

    // attenuation 2
    wr(8'hD7, low, rs0, rs1);
    chk("att2_7", 32'(atten2), 32'h7);
    wr(8'h0A, low, rs0, rs1);
    chk("att2_A", 32'(atten2), 32'hA);
    chk("tone2_0", 32'(tone2_freq), 32'h0);

    // second edge 5 clocks into busy is dropped and does not extend busy
    data = 8'h81; we = 1'b1;
    @(negedge clk); we = 1'b0;
    low = 1;
    ticks(4); low += 4;
    data = 8'h8C; we = 1'b1;
    @(negedge clk); we = 1'b0; low++;
    while (!ready && low < 2000) begin @(negedge clk); low++; end
    low--;  // loop counted the first ready-high negedge
    chk("drop_len",  32'(low), 32'(RC));
    chk("drop_tone", 32'(tone0_freq), 32'h0F1);

    // we held high 100 clocks: one write; data change later is ignored
    data = 8'hB3; we = 1'b1;
    low = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ready) low++;
      if (i == 40) data = 8'hB9;
    end
    we = 1'b0;
    ticks(1);
    chk("hold_len",  32'(low), 32'(RC));
    chk("hold_att1", 32'(atten1), 32'h3);

    // enable every 4th clock: align the write with an enable pulse
    en_div4 = 1;
    low = 0;
    do begin @(negedge clk); #1; low++; end while (!enable && low < 20);
    wr(8'h9B, low, rs0, rs1);
    chk("div4_len", 32'(low), 32'(4 * RC));
    chk("att0_B",   32'(atten0), 32'hB);

    // reset 50 clocks into busy
    data = 8'hC2; we = 1'b1;
    @(negedge clk); we = 1'b0;
    chk("pre_rst_tone2", 32'(tone2_freq), 32'h2);
    ticks(49);
    chk("busy_at50", 32'(ready), 32'd0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_tone0", 32'(tone0_freq), 32'h0);
    chk("mid_rst_att0",  32'(atten0), 32'hF);
    en_div4 = 0;

    // reset coincident with a write edge: write lost
    data = 8'h95; we = 1'b1; reset = 1'b1;
    @(negedge clk); reset = 1'b0; we = 1'b0;
    ticks(1);
    chk("rst_wins_att0",  32'(atten0), 32'hF);
    chk("rst_wins_ready", 32'(ready), 32'd1);

    // data byte after tone1 latch; bit 6 ignored
    wr(8'hA4, low, rs0, rs1);
    wr(8'h7F, low, rs0, rs1);
    chk("tone1_3F4", 32'(tone1_freq), 32'h3F4);
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
